// File: rtl/sram_bridge_pkg.sv
// Shared types for the LSU-to-SRAM bridge: FSM state encoding, access sizes
// and the alignment rule applied to incoming requests.
package sram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size 2'b11 is handled exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/sram_lane_align.sv
// Combinational byte-lane logic: store data replication with byte mask, and
// load data extraction with sign/zero extension.
module sram_lane_align
    import sram_bridge_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_raw_i,
    output logic [31:0] store_rep_o,
    output logic [3:0]  bmask_o,
    output logic [31:0] load_ext_o
);

    logic [31:0] shifted;
    logic        sign_bit;

    always_comb begin
        shifted     = load_raw_i >> {lane_i, 3'b000};
        sign_bit    = 1'b0;
        store_rep_o = store_data_i;
        bmask_o     = 4'b1111;
        load_ext_o  = shifted;
        case (size_i)
            SZ_BYTE: begin
                sign_bit    = shifted[7] & ~unsigned_i;
                store_rep_o = {4{store_data_i[7:0]}};
                bmask_o     = 4'b0001 << lane_i;
                load_ext_o  = {{24{sign_bit}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sign_bit    = shifted[15] & ~unsigned_i;
                store_rep_o = {2{store_data_i[15:0]}};
                bmask_o     = lane_i[1] ? 4'b1100 : 4'b0011;
                load_ext_o  = {{16{sign_bit}}, shifted[15:0]};
            end
            default: begin
                store_rep_o = store_data_i;
                bmask_o     = 4'b1111;
                load_ext_o  = shifted;
            end
        endcase
    end

endmodule

// File: rtl/sram_lsu_bridge.sv
// Bridges a single-outstanding LSU port onto a halfword-addressed SRAM controller.
// Optional macro SRAM_BRIDGE_TIMEOUT_EN bounds the ACK wait and adds o_lsu_error.
module sram_lsu_bridge
    import sram_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    input  logic [1:0]  i_lsu_size,
    input  logic        i_lsu_unsigned,
    input  logic        i_lsu_wren,
    input  logic        i_lsu_rden,
    output logic [31:0] o_lsu_rdata,
    output logic        o_lsu_stall,
    output logic        o_lsu_done,
    output logic        o_lsu_misaligned,
    output logic [17:0] o_ADDR,
    output logic [31:0] o_WDATA,
    output logic [3:0]  o_BMASK,
    output logic        o_WREN,
    output logic        o_RDEN,
    input  logic [31:0] i_RDATA,
    input  logic        i_ACK
`ifdef SRAM_BRIDGE_TIMEOUT_EN
    ,
    output logic        o_lsu_error
`endif
);

    state_e      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic        uns_q, uns_d;
    logic        store_q, store_d;
    logic        mis_q, mis_d;
    logic [31:0] rdata_q, rdata_d;
    logic [17:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  bmask_q, bmask_d;

    logic        req;
    logic        in_idle;
    logic [1:0]  la_size, la_lane;
    logic        la_uns;
    logic [31:0] la_rep, la_load;
    logic [3:0]  la_bmask;
    logic        unused_addr;

    assign unused_addr = ^i_lsu_addr[31:19];
    assign req         = i_lsu_wren | i_lsu_rden;
    assign in_idle     = (state_q == IDLE);

    // Live request fields drive the aligner while accepting; the latched ones during the wait.
    assign la_size = in_idle ? i_lsu_size     : size_q;
    assign la_lane = in_idle ? i_lsu_addr[1:0] : lane_q;
    assign la_uns  = in_idle ? i_lsu_unsigned : uns_q;

    sram_lane_align u_align (
        .size_i       (la_size),
        .lane_i       (la_lane),
        .unsigned_i   (la_uns),
        .store_data_i (i_lsu_wdata),
        .load_raw_i   (i_RDATA),
        .store_rep_o  (la_rep),
        .bmask_o      (la_bmask),
        .load_ext_o   (la_load)
    );

`ifdef SRAM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        lane_d  = lane_q;
        uns_d   = uns_q;
        store_d = store_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bmask_d = bmask_q;
`ifdef SRAM_BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    size_d  = i_lsu_size;
                    lane_d  = i_lsu_addr[1:0];
                    uns_d   = i_lsu_unsigned;
                    store_d = i_lsu_wren;
                    mis_d   = is_misaligned(i_lsu_size, i_lsu_addr[1:0]);
`ifdef SRAM_BRIDGE_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    if (is_misaligned(i_lsu_size, i_lsu_addr[1:0])) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = {i_lsu_addr[18:2], 1'b0};
                        wdata_d = la_rep;
                        bmask_d = la_bmask;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef SRAM_BRIDGE_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (i_ACK) begin
                    if (!store_q) begin
                        rdata_d = la_load;
                    end
                    state_d = DONE;
                end
`ifdef SRAM_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= IDLE;
            size_q  <= '0;
            lane_q  <= '0;
            uns_q   <= 1'b0;
            store_q <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            bmask_q <= '0;
`ifdef SRAM_BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
            uns_q   <= uns_d;
            store_q <= store_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bmask_q <= bmask_d;
`ifdef SRAM_BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign o_lsu_rdata      = rdata_q;
    assign o_ADDR           = addr_q;
    assign o_WDATA          = wdata_q;
    assign o_BMASK          = bmask_q;
    assign o_WREN           = (state_q == ISSUE) &  store_q;
    assign o_RDEN           = (state_q == ISSUE) & ~store_q;
    assign o_lsu_done       = (state_q == DONE);
    assign o_lsu_misaligned = (state_q == DONE) & mis_q;
    assign o_lsu_stall      = (state_q == ISSUE) | (state_q == WAIT) | (in_idle & req);
`ifdef SRAM_BRIDGE_TIMEOUT_EN
    assign o_lsu_error      = (state_q == DONE) & err_q;
`endif

endmodule

// File: doc/sram_lsu_bridge.md
SRAM_LSU_BRIDGE -- requirements
Module: sram_lsu_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 15, meaning maximum cycles to wait for i_ACK (used only with SRAM_BRIDGE_TIMEOUT_EN).
REQ-002 The block SHALL have input i_clk, 1 bit: clock; reset i_reset, synchronous, active-low.
REQ-003 The block SHALL have input i_reset, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have input i_lsu_addr, 32 bits: byte address; only bits [18:0] are used.
REQ-005 The block SHALL have input i_lsu_wdata, 32 bits: store data, right-justified.
REQ-006 The block SHALL have input i_lsu_size, 2 bits: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 The block SHALL have inputs i_lsu_unsigned, i_lsu_wren and i_lsu_rden, 1 bit each: zero-extend load, store request, load request.
REQ-008 The block SHALL have outputs o_lsu_rdata (32 bits: extended load data), o_lsu_stall, o_lsu_done and o_lsu_misaligned (1 bit each).
REQ-009 The block SHALL have outputs o_ADDR (18 bits: halfword address), o_WDATA (32 bits), o_BMASK (4 bits), o_WREN and o_RDEN (1 bit each), toward the SRAM controller.
REQ-010 The block SHALL have inputs i_RDATA (32 bits) and i_ACK (1 bit) from the SRAM controller.
REQ-011 The block SHALL have output o_lsu_error, 1 bit: timeout pulse, present only with SRAM_BRIDGE_TIMEOUT_EN.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-013 In IDLE, a request (wren|rden) SHALL be registered and the FSM SHALL move to ISSUE; if both are set, the store SHALL win.
REQ-014 A misaligned request (half with addr[0]=1; word with addr[1:0]!=0) SHALL NOT issue, SHALL pulse o_lsu_misaligned with o_lsu_done, and SHALL go IDLE->DONE.
REQ-015 ISSUE SHALL last exactly one cycle with o_WREN or o_RDEN high, then go to WAIT; o_WREN/o_RDEN SHALL be low in all other states.
REQ-016 o_ADDR SHALL be {addr[18:2],1'b0}.
REQ-017 o_BMASK SHALL be 1<<addr[1:0] for byte, 0011 or 1100 by addr[1] for half, and 1111 for word.
REQ-018 o_WDATA SHALL replicate store data: {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-019 WAIT SHALL hold until i_ACK; on i_ACK, a load SHALL register i_RDATA shifted by lane (8*addr[1:0]), sign- or zero-extended to 32 bits, into o_lsu_rdata, and the FSM SHALL go to DONE.
REQ-020 DONE SHALL last one cycle with o_lsu_done=1, then return to IDLE; requests in DONE SHALL be ignored.
REQ-021 o_lsu_stall SHALL be 1 in ISSUE and WAIT, and combinationally 1 in IDLE when a request is present.
REQ-022 Aligned latency SHALL be: store done at cycle 4 and load done at cycle 7 after the accept cycle 0, given the 2/5-cycle controller.
REQ-023 o_lsu_rdata SHALL hold its value until the next load completes; stores SHALL NOT alter it.

Reset
REQ-024 On i_reset=0 at a clock edge, the FSM SHALL enter IDLE from any state, including mid-WAIT, and any in-flight access SHALL be abandoned.
REQ-025 Reset SHALL clear all registered outputs and fields (o_lsu_rdata, o_ADDR, o_WDATA, o_BMASK, flags, timeout counter) to 0.

Configuration
REQ-026 With SRAM_BRIDGE_TIMEOUT_EN defined, a WAIT counter SHALL force DONE with o_lsu_error=1 and o_lsu_rdata unchanged after TIMEOUT_CYCLES cycles without i_ACK.
REQ-027 Without SRAM_BRIDGE_TIMEOUT_EN, WAIT SHALL be unbounded and the o_lsu_error port and counter SHALL be absent.

Structure
REQ-028 A shared package sram_bridge_pkg SHALL hold the state enum and the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
REQ-029 Lane/extension logic SHALL be a sub-module sram_lane_align, combinational, with both store-replicate and load-extract paths.

Verification
REQ-030 Store word 0xDEADBEEF @0x00010 -> o_ADDR=0x00008, BMASK=1111, one-cycle WREN, done at cycle 4.
REQ-031 Store byte 0xA5 @0x00003 then signed load byte @0x00003 -> BMASK=1000, o_lsu_rdata=0xFFFFFFA5 at cycle 7; unsigned load -> 0x000000A5.
REQ-032 Load half @0x00006 with i_RDATA=0x8001xxxx -> signed 0xFFFF8001, unsigned 0x00008001.
REQ-033 Load word @0x00002 -> no RDEN, o_lsu_misaligned=1 and done at cycle 1.
REQ-034 Reset asserted in WAIT -> next cycle IDLE, all outputs 0; and with the macro, i_ACK withheld -> o_lsu_error at WAIT+15.
